gb_cb_sequencer: RTL and testbench
==================================

Name: gb_cb_sequencer

Overview:
- Multi-cycle executor for Gameboy CB-prefixed instructions (rotate/shift/SWAP/BIT/RES/SET).
- Sits between the CPU decoder and the registered ALU. It is the issuing side of the ALU op/operand/result/flag interface.
- Fetches the operand from the register file or from (HL) memory, issues the op to the ALU, then writes back the result with per-op flag masking.
- One instruction in flight at a time.

Parameters:
ACK_TIMEOUT, 0, cycles to wait for mem_ack before aborting with err. 0 = wait forever.
TMO_W, 8, width of the timeout counter.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle request; opcode valid in the same cycle
opcode  in  8  CB opcode byte (the byte after 0xCB)
flags_in  in  4  current F as {Z,N,H,C}
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle memory-timeout abort pulse
rf_rsel  out  3  register read index (0 B,1 C,2 D,3 E,4 H,5 L,7 A)
rf_rdata  in  8  combinational read data for rf_rsel
rf_we  out  1  register write strobe
rf_wsel  out  3  register write index
rf_wdata  out  8  register write data
mem_req  out  1  (HL) access request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_wdata  out  8  memory write data
mem_rdata  in  8  read data, valid in the mem_ack cycle
mem_ack  in  1  access complete
alu_a  out  8  ALU operand a
alu_b  out  8  ALU operand b ({5'b0, bit index})
alu_c  out  1  ALU carry in
alu_op  out  6  ALU opcode
alu_r  in  8  ALU result, registered; valid one cycle after issue
alu_znhc  in  4  ALU flags, registered; valid one cycle after issue
flags_we  out  1  F write strobe
flags_out  out  4  F write data {Z,N,H,C}

Behaviour:
- Decode:
  - opcode[7:6]=00: opcode[5:3] selects 0 RLC=13, 1 RRC=15, 2 RL=12, 3 RR=14, 4 SLA=16, 5 SRA=17, 6 SWAP=11, 7 SRL=18.
  - opcode[7:6]=01 BIT=10; 10 RES=9; 11 SET=8.
  - Bit index = opcode[5:3]. Target = opcode[2:0]; 6 = (HL).
- Moore FSM. States: IDLE, READ, EXEC, RESULT, MEMWR, DONE.
- IDLE:
  - start=1 latches opcode and flags_in[0] -> READ.
  - start while busy is ignored, including in the DONE cycle.
- READ, register target: rf_rsel = target; capture rf_rdata -> EXEC.
- READ, memory target:
  - mem_req=1, mem_we=0 until mem_ack.
  - Capture mem_rdata in the ack cycle -> EXEC.
- EXEC:
  - Drive alu_a = operand, alu_b = bit index, alu_c = latched C, alu_op = decoded op.
  - The ALU samples at this edge -> RESULT.
- RESULT: alu_r/alu_znhc are valid.
  - Flags:
    - Shift/rotate/SWAP: flags_we=1, flags_out=alu_znhc.
    - BIT: flags_we=1, flags_out={alu_znhc[3:1], latched C}.
    - RES/SET: flags_we=0.
  - Register target, non-BIT: rf_we=1, rf_wsel=target, rf_wdata=alu_r -> DONE.
  - Memory target, non-BIT: latch alu_r into mem_wdata -> MEMWR.
  - BIT (any target): no data write -> DONE.
- MEMWR: mem_req=1, mem_we=1, mem_wdata held until mem_ack -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Outside EXEC: alu_op = NOP (19), alu_a = 0, alu_b = 0, alu_c = 0.
- Latency (start edge = cycle 0, ack in the first request cycle):
  - Register target: done in cycle 4.
  - Memory BIT: done in cycle 4.
  - Memory SET/RES/shift: done in cycle 5.
  - Each extra mem_ack wait cycle adds 1.
- Timeout (ACK_TIMEOUT>0):
  - Counter clears on entering READ/MEMWR and increments each cycle mem_req=1 without ack.
  - When it reaches ACK_TIMEOUT: err=1 for one cycle, mem_req drops, -> IDLE.
  - No rf_we. No done. A flags write already made in RESULT stands.
- mem_ack outside READ/MEMWR is ignored.
- Reset (reset_n=0 at an edge) forces the following, including mid-operation:
  - State -> IDLE; busy, done, err, rf_we, mem_req, mem_we, flags_we = 0.
  - alu_op = 19; all data/index outputs = 0; timeout counter = 0.
  - An in-flight instruction is abandoned with no writeback.

Test Plan:
1. RL C: opcode 0x11, rf_rdata 0x80, flags_in 0000 -> EXEC: alu_op=12, alu_a=0x80, alu_c=0; RESULT: rf_we, wsel=1, wdata=0x00, flags_out=1001; done at cycle 4.
2. BIT 7,(HL): opcode 0x7E, flags_in C=1, mem_ack after 2 wait cycles, mem_rdata 0x7F -> flags_out=1011, no rf_we, no mem write; done at cycle 6.
3. SET 0,(HL): opcode 0xC6, mem_rdata 0x10 -> MEMWR: mem_we=1, mem_wdata=0x11; flags_we never asserted; done after write ack.
4. SWAP A: opcode 0x37, rf_rdata 0xF0 -> rf_wsel=7, wdata=0x0F, flags_out=0000; second start during busy is ignored (exactly one done).
5. Reset mid-MEMWR: reset_n=0 while mem_req=1 -> next cycle mem_req=0, busy=0, alu_op=19; no done.
6. ACK_TIMEOUT=4, RES 3,(HL) (0x9E), mem_ack tied 0 -> err pulse after 4 request cycles, back to IDLE, no done, no writes.

Source files
------------

// File: rtl/gb_cb_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gb_cb_sequencer                                               |
// | Purpose  : Multi-cycle executor for Gameboy CB-prefixed instructions.    |
// |            Fetches the operand (register file or (HL)), issues the op    |
// |            to the registered ALU, then writes back result and flags.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module gb_cb_sequencer #(
  parameter int ACK_TIMEOUT = 0,
  parameter int TMO_W       = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] opcode,
  input  logic [3:0] flags_in,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] rf_rsel,
  input  logic [7:0] rf_rdata,
  output logic       rf_we,
  output logic [2:0] rf_wsel,
  output logic [7:0] rf_wdata,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_c,
  output logic [5:0] alu_op,
  input  logic [7:0] alu_r,
  input  logic [3:0] alu_znhc,
  output logic       flags_we,
  output logic [3:0] flags_out
);

  localparam logic [5:0] c_OP_SET  = 6'd8;
  localparam logic [5:0] c_OP_RES  = 6'd9;
  localparam logic [5:0] c_OP_BIT  = 6'd10;
  localparam logic [5:0] c_OP_SWAP = 6'd11;
  localparam logic [5:0] c_OP_RL   = 6'd12;
  localparam logic [5:0] c_OP_RLC  = 6'd13;
  localparam logic [5:0] c_OP_RR   = 6'd14;
  localparam logic [5:0] c_OP_RRC  = 6'd15;
  localparam logic [5:0] c_OP_SLA  = 6'd16;
  localparam logic [5:0] c_OP_SRA  = 6'd17;
  localparam logic [5:0] c_OP_SRL  = 6'd18;
  localparam logic [5:0] c_OP_NOP  = 6'd19;

  localparam logic [2:0] c_TGT_HL = 3'd6;

  // A zero ACK_TIMEOUT disables the abort path entirely.
  localparam bit             c_TMO_EN   = (ACK_TIMEOUT > 0);
  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_EXEC   = 3'd2,
    S_RESULT = 3'd3,
    S_MEMWR  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           r_state;
  logic [5:0]       r_op;
  logic [2:0]       r_bit;
  logic [2:0]       r_tgt;
  logic             r_c;
  logic [TMO_W-1:0] r_tmo;

  logic [5:0] w_dec_op;
  logic       w_mem_tgt;
  logic       w_is_bit;
  logic       w_is_resset;
  logic       w_read_ok;
  logic [7:0] w_operand;
  logic       w_tmo_hit;
  logic       w_unused;

  assign w_mem_tgt   = (r_tgt == c_TGT_HL);
  assign w_is_bit    = (r_op == c_OP_BIT);
  assign w_is_resset = (r_op == c_OP_RES) || (r_op == c_OP_SET);
  assign w_read_ok   = !w_mem_tgt || mem_ack;
  assign w_operand   = w_mem_tgt ? mem_rdata : rf_rdata;
  assign w_tmo_hit   = c_TMO_EN && (r_tmo == c_TMO_LAST);
  // Only the carry of the incoming F is needed; Z/N/H come from the ALU.
  assign w_unused    = ^flags_in[3:1];

  // Decode the CB opcode byte into the ALU operation code.
  always_comb begin
    w_dec_op = c_OP_NOP;
    unique case (opcode[7:6])
      2'b00: begin
        unique case (opcode[5:3])
          3'd0: w_dec_op = c_OP_RLC;
          3'd1: w_dec_op = c_OP_RRC;
          3'd2: w_dec_op = c_OP_RL;
          3'd3: w_dec_op = c_OP_RR;
          3'd4: w_dec_op = c_OP_SLA;
          3'd5: w_dec_op = c_OP_SRA;
          3'd6: w_dec_op = c_OP_SWAP;
          default: w_dec_op = c_OP_SRL;
        endcase
      end
      2'b01:   w_dec_op = c_OP_BIT;
      2'b10:   w_dec_op = c_OP_RES;
      default: w_dec_op = c_OP_SET;
    endcase
  end

  // Writeback strobes follow the ALU result, which is only valid during RESULT,
  // so they are decoded from the state rather than registered a cycle late.
  always_comb begin
    rf_we     = 1'b0;
    rf_wsel   = 3'd0;
    rf_wdata  = 8'd0;
    flags_we  = 1'b0;
    flags_out = 4'd0;
    if (r_state == S_RESULT) begin
      if (!w_is_bit && !w_mem_tgt) begin
        rf_we    = 1'b1;
        rf_wsel  = r_tgt;
        rf_wdata = alu_r;
      end
      if (!w_is_resset) begin
        flags_we  = 1'b1;
        flags_out = w_is_bit ? {alu_znhc[3:1], r_c} : alu_znhc;
      end
    end
  end

  // Sequencer state machine with registered control and ALU issue outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_op      <= c_OP_NOP;
      r_bit     <= 3'd0;
      r_tgt     <= 3'd0;
      r_c       <= 1'b0;
      r_tmo     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rf_rsel   <= 3'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'd0;
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      alu_c     <= 1'b0;
      alu_op    <= c_OP_NOP;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_READ;
            busy    <= 1'b1;
            r_op    <= w_dec_op;
            r_bit   <= opcode[5:3];
            r_tgt   <= opcode[2:0];
            r_c     <= flags_in[0];
            r_tmo   <= '0;
            if (opcode[2:0] == c_TGT_HL) begin
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end else begin
              rf_rsel <= opcode[2:0];
            end
          end
        end
        S_READ: begin
          if (w_read_ok) begin
            r_state <= S_EXEC;
            rf_rsel <= 3'd0;
            mem_req <= 1'b0;
            alu_a   <= w_operand;
            alu_b   <= {5'd0, r_bit};
            alu_c   <= r_c;
            alu_op  <= r_op;
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            err     <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_EXEC: begin
          // The ALU captured its operands at this edge; return the bus to NOP.
          r_state <= S_RESULT;
          alu_a   <= 8'd0;
          alu_b   <= 8'd0;
          alu_c   <= 1'b0;
          alu_op  <= c_OP_NOP;
        end
        S_RESULT: begin
          if (w_is_bit || !w_mem_tgt) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_state   <= S_MEMWR;
            mem_wdata <= alu_r;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            r_tmo     <= '0;
          end
        end
        S_MEMWR: begin
          if (mem_ack) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            err     <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gb_cb_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_gb_cb_sequencer                                            |
// | Purpose  : Self-checking bench for gb_cb_sequencer with a behavioural    |
// |            registered ALU, register file and (HL) memory responder.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_gb_cb_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] opcode;
  logic [3:0] flags_in;
  logic       busy, done, err;
  logic [2:0] rf_rsel;
  logic [7:0] rf_rdata;
  logic       rf_we;
  logic [2:0] rf_wsel;
  logic [7:0] rf_wdata;
  logic       mem_req, mem_we;
  logic [7:0] mem_wdata, mem_rdata;
  logic       mem_ack;
  logic [7:0] alu_a, alu_b;
  logic       alu_c;
  logic [5:0] alu_op;
  logic [7:0] alu_r;
  logic [3:0] alu_znhc;
  logic       flags_we;
  logic [3:0] flags_out;

  logic [7:0] regs [8];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign rf_rdata = regs[rf_rsel];

  gb_cb_sequencer #(.ACK_TIMEOUT(4), .TMO_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .flags_in(flags_in), .busy(busy), .done(done), .err(err),
    .rf_rsel(rf_rsel), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .rf_wdata(rf_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_op(alu_op),
    .alu_r(alu_r), .alu_znhc(alu_znhc), .flags_we(flags_we), .flags_out(flags_out)
  );

  // Behavioural ALU: result and flags registered one cycle after issue.
  function automatic logic [11:0] alu_model(input logic [5:0] op, input logic [7:0] a,
                                            input logic [2:0] b, input logic c);
    logic [7:0] r;
    logic [3:0] f;
    r = a;
    f = 4'd0;
    case (op)
      6'd8:  r = a | (8'd1 << b);
      6'd9:  r = a & ~(8'd1 << b);
      6'd10: f = {~a[b], 1'b0, 1'b1, 1'b0};
      6'd11: begin r = {a[3:0], a[7:4]}; f = {(r == 8'd0), 3'b000}; end
      6'd12: begin r = {a[6:0], c};      f = {(r == 8'd0), 2'b00, a[7]}; end
      6'd13: begin r = {a[6:0], a[7]};   f = {(r == 8'd0), 2'b00, a[7]}; end
      6'd14: begin r = {c, a[7:1]};      f = {(r == 8'd0), 2'b00, a[0]}; end
      6'd15: begin r = {a[0], a[7:1]};   f = {(r == 8'd0), 2'b00, a[0]}; end
      6'd16: begin r = {a[6:0], 1'b0};   f = {(r == 8'd0), 2'b00, a[7]}; end
      6'd17: begin r = {a[7], a[7:1]};   f = {(r == 8'd0), 2'b00, a[0]}; end
      6'd18: begin r = {1'b0, a[7:1]};   f = {(r == 8'd0), 2'b00, a[0]}; end
      default: begin r = 8'd0; f = 4'd0; end
    endcase
    return {r, f};
  endfunction

  always @(posedge clock) begin
    {alu_r, alu_znhc} <= alu_model(alu_op, alu_a, alu_b[2:0], alu_c);
  end

  typedef struct {
    logic [7:0] opc;
    logic [3:0] fin;
    logic [7:0] opnd;
    int         rd_wait;
    int         wr_wait;
    int         hold;
    logic [5:0] e_op;
    logic       e_c;
    logic       e_rf;
    logic [7:0] e_wd;
    logic       e_fw;
    logic [3:0] e_fl;
    logic       e_mw;
    logic [7:0] e_mwd;
    int         e_done;
  } vec_t;

  vec_t vecs [14];
  vec_t sb_q [$];

  function automatic vec_t mk(input logic [7:0] opc, input logic [3:0] fin, input logic [7:0] opnd,
                              input int rdw, input int wrw, input int hold,
                              input logic [5:0] eop, input logic ec,
                              input logic erf, input logic [7:0] ewd,
                              input logic efw, input logic [3:0] efl,
                              input logic emw, input logic [7:0] emwd, input int edone);
    vec_t v;
    v.opc = opc; v.fin = fin; v.opnd = opnd;
    v.rd_wait = rdw; v.wr_wait = wrw; v.hold = hold;
    v.e_op = eop; v.e_c = ec; v.e_rf = erf; v.e_wd = ewd;
    v.e_fw = efw; v.e_fl = efl; v.e_mw = emw; v.e_mwd = emwd; v.e_done = edone;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic init_regs();
    for (int i = 0; i < 8; i++) regs[i] = 8'hA0 + 8'(i);
  endtask

  // Drive one instruction from the table, observe it cycle by cycle, then
  // pop its expectation from the scoreboard and compare.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int cyc, dcyc, ndone, nerr, nexec, nrf, nfl, nmw, rdw, wrw, badpost;
    logic bad_idle;
    logic [5:0] g_op;
    logic [7:0] g_a, g_b, g_wd, g_mwd;
    logic       g_c;
    logic [2:0] g_ws;
    logic [3:0] g_fl;
    string      p;
    p = $sformatf("v%0d", idx);
    cyc = 0; dcyc = -1; ndone = 0; nerr = 0; nexec = 0; nrf = 0; nfl = 0; nmw = 0;
    rdw = 0; wrw = 0; badpost = 0; bad_idle = 1'b0;
    g_op = '0; g_a = '0; g_b = '0; g_c = 1'b0; g_ws = '0; g_wd = '0; g_fl = '0; g_mwd = '0;
    init_regs();
    if (v.opc[2:0] != 3'd6) regs[v.opc[2:0]] = v.opnd;
    mem_rdata = v.opnd;
    opcode    = v.opc;
    flags_in  = v.fin;
    sb_q.push_back(v);
    for (int k = 0; k < 40; k++) begin
      start   = (cyc < v.hold);
      mem_ack = 1'b0;
      if (mem_req && !mem_we) begin
        if (rdw == v.rd_wait) mem_ack = 1'b1; else rdw++;
      end
      if (mem_req && mem_we) begin
        if (wrw == v.wr_wait) begin mem_ack = 1'b1; nmw++; g_mwd = mem_wdata; end
        else wrw++;
      end
      step();
      cyc++;
      if (alu_op != 6'd19) begin
        nexec++; g_op = alu_op; g_a = alu_a; g_b = alu_b; g_c = alu_c;
      end else if (alu_a != 8'd0 || alu_b != 8'd0 || alu_c != 1'b0) begin
        bad_idle = 1'b1;
      end
      if (rf_we)    begin nrf++; g_ws = rf_wsel; g_wd = rf_wdata; end
      if (flags_we) begin nfl++; g_fl = flags_out; end
      if (err) nerr++;
      if (cyc == 1) chk({p, " busy_c1"}, busy, 1);
      if (done) begin ndone++; if (dcyc < 0) dcyc = cyc; end
      if (dcyc >= 0 && cyc == dcyc + 1) break;
    end
    // Idle window: late starts are gone and a stray ack must do nothing.
    for (int k = 0; k < 3; k++) begin
      if (busy || done || rf_we || mem_req) badpost++;
      start   = 1'b0;
      mem_ack = (k == 1);
      step();
    end
    mem_ack = 1'b0;
    if (busy || done) badpost++;
    e = sb_q.pop_front();
    chk({p, " exec_cycles"}, nexec, 1);
    chk({p, " alu_op"}, g_op, e.e_op);
    chk({p, " alu_a"}, g_a, e.opnd);
    chk({p, " alu_b"}, g_b, {5'd0, e.opc[5:3]});
    chk({p, " alu_c"}, g_c, e.e_c);
    chk({p, " alu_idle_zero"}, bad_idle, 0);
    chk({p, " done_cycle"}, dcyc, e.e_done);
    chk({p, " done_count"}, ndone, 1);
    chk({p, " err_count"}, nerr, 0);
    chk({p, " post_idle"}, badpost, 0);
    chk({p, " rf_we_count"}, nrf, e.e_rf);
    if (e.e_rf) begin
      chk({p, " rf_wsel"}, g_ws, e.opc[2:0]);
      chk({p, " rf_wdata"}, g_wd, e.e_wd);
    end
    chk({p, " flags_we_count"}, nfl, e.e_fw);
    if (e.e_fw) chk({p, " flags_out"}, g_fl, e.e_fl);
    chk({p, " mem_write_count"}, nmw, e.e_mw);
    if (e.e_mw) chk({p, " mem_wdata"}, g_mwd, e.e_mwd);
  endtask

  initial begin
    int ecyc, nreq, nbad, found;
    //              opc    fin    opnd  rdw wrw hold op c  rf  wdata  fw  flags   mw  mwdata done
    vecs[0]  = mk(8'h11, 4'b0000, 8'h80, 0, 0, 1, 12, 0, 1, 8'h00, 1, 4'b1001, 0, 8'h00, 4); // RL C
    vecs[1]  = mk(8'h7E, 4'b0001, 8'h7F, 2, 0, 1, 10, 1, 0, 8'h00, 1, 4'b1011, 0, 8'h00, 6); // BIT 7,(HL)
    vecs[2]  = mk(8'hC6, 4'b0000, 8'h10, 0, 0, 1,  8, 0, 0, 8'h00, 0, 4'b0000, 1, 8'h11, 5); // SET 0,(HL)
    vecs[3]  = mk(8'h37, 4'b0000, 8'hF0, 0, 0, 5, 11, 0, 1, 8'h0F, 1, 4'b0000, 0, 8'h00, 4); // SWAP A
    vecs[4]  = mk(8'h00, 4'b0000, 8'h85, 0, 0, 1, 13, 0, 1, 8'h0B, 1, 4'b0001, 0, 8'h00, 4); // RLC B
    vecs[5]  = mk(8'h0A, 4'b0000, 8'h01, 0, 0, 1, 15, 0, 1, 8'h80, 1, 4'b0001, 0, 8'h00, 4); // RRC D
    vecs[6]  = mk(8'h1B, 4'b0001, 8'h01, 0, 0, 1, 14, 1, 1, 8'h80, 1, 4'b0001, 0, 8'h00, 4); // RR E
    vecs[7]  = mk(8'h24, 4'b0000, 8'h80, 0, 0, 1, 16, 0, 1, 8'h00, 1, 4'b1001, 0, 8'h00, 4); // SLA H
    vecs[8]  = mk(8'h2D, 4'b0000, 8'h81, 0, 0, 1, 17, 0, 1, 8'hC0, 1, 4'b0001, 0, 8'h00, 4); // SRA L
    vecs[9]  = mk(8'h3F, 4'b0000, 8'h01, 0, 0, 1, 18, 0, 1, 8'h00, 1, 4'b1001, 0, 8'h00, 4); // SRL A
    vecs[10] = mk(8'h9E, 4'b0000, 8'hFF, 1, 0, 1,  9, 0, 0, 8'h00, 0, 4'b0000, 1, 8'hF7, 6); // RES 3,(HL)
    vecs[11] = mk(8'h40, 4'b0001, 8'h01, 0, 0, 1, 10, 1, 0, 8'h00, 1, 4'b0011, 0, 8'h00, 4); // BIT 0,B
    vecs[12] = mk(8'hFF, 4'b0000, 8'h00, 0, 0, 1,  8, 0, 1, 8'h80, 0, 4'b0000, 0, 8'h00, 4); // SET 7,A
    vecs[13] = mk(8'h36, 4'b0000, 8'h12, 0, 1, 1, 11, 0, 0, 8'h00, 1, 4'b0000, 1, 8'h21, 6); // SWAP (HL)

    init_regs();
    reset_n = 1'b0; start = 1'b0; opcode = 8'd0; flags_in = 4'd0;
    mem_rdata = 8'd0; mem_ack = 1'b0;
    step(); step(); step();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset rf_we", rf_we, 0);
    chk("reset flags_we", flags_we, 0);
    chk("reset alu_op", alu_op, 19);
    chk("reset alu_a", alu_a, 0);
    chk("reset rf_rsel", rf_rsel, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Reset while the (HL) write of SET 0,(HL) is outstanding.
    init_regs();
    mem_rdata = 8'h10; opcode = 8'hC6; flags_in = 4'd0; start = 1'b1; mem_ack = 1'b0;
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      start = 1'b0;
      if (mem_req && mem_we) begin found = 1; break; end
      mem_ack = mem_req && !mem_we;
    end
    mem_ack = 1'b0;
    chk("rst_mid found_memwr", found, 1);
    chk("rst_mid mem_wdata", mem_wdata, 8'h11);
    reset_n = 1'b0;
    step();
    chk("rst_mid mem_req", mem_req, 0);
    chk("rst_mid mem_we", mem_we, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid alu_op", alu_op, 19);
    chk("rst_mid mem_wdata_clr", mem_wdata, 0);
    reset_n = 1'b1;
    nbad = 0;
    for (int k = 0; k < 4; k++) begin
      if (done || busy || mem_req) nbad++;
      step();
    end
    chk("rst_mid no_done", nbad, 0);

    // RES 3,(HL) with the memory never acknowledging.
    init_regs();
    mem_rdata = 8'hFF; opcode = 8'h9E; flags_in = 4'd0; start = 1'b1; mem_ack = 1'b0;
    ecyc = -1; nreq = 0; nbad = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      start = 1'b0;
      if (mem_req) nreq++;
      if (rf_we || flags_we || done || (mem_req && mem_we)) nbad++;
      if (err) begin
        ecyc = k;
        chk("tmo busy_at_err", busy, 0);
        chk("tmo mem_req_at_err", mem_req, 0);
        break;
      end
    end
    chk("tmo err_cycle", ecyc, 5);
    chk("tmo request_cycles", nreq, 4);
    chk("tmo no_writes", nbad, 0);
    step();
    chk("tmo err_pulse", err, 0);
    chk("tmo idle_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
